// File: rtl/cpu_pkg.sv
// Constants shared across the phase-3 CPU datapath: register index width,
// datapath width, and the default register-file geometry.
package cpu_pkg;

    localparam int REG_IDX_W        = 6;
    localparam int DATA_W           = 64;
    localparam int NREGS_DEFAULT    = 32;
    localparam int ZERO_REG_DEFAULT = 31;

endpackage

// File: rtl/onehot_enc_64.sv
// Converts a 64-bit one-hot vector to its binary index, and flags whether
// exactly one bit is set so that malformed selects can be rejected upstream.
module onehot_enc_64
    import cpu_pkg::*;
(
    input  logic [63:0]          vec,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 onehot_ok
);

    logic seen;
    logic multi;

    // OR-ing the set positions is exact for a legal one-hot vector; any
    // other pattern is marked not-ok, so the merged index is never used.
    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (vec[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                idx  = idx | REG_IDX_W'(i);
            end
        end
        onehot_ok = seen && !multi;
    end

endmodule

// File: rtl/regfile_onehot_wr.sv
// Architectural register file written through a one-hot select from the
// write-back decoder, with two combinational read ports and write-through bypass.
module regfile_onehot_wr
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [63:0]          wr_sel,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [REG_IDX_W-1:0] rd_a_idx,
    input  logic [REG_IDX_W-1:0] rd_b_idx,
    output logic [DATA_W-1:0]    rd_a_data,
    output logic [DATA_W-1:0]    rd_b_data,
    output logic                 wr_err,
    input  logic                 err_clr,
    output logic [REG_IDX_W-1:0] last_wr_idx,
    output logic                 last_wr_vld
);

    logic [DATA_W-1:0]    regs [NREGS];
    logic [REG_IDX_W-1:0] wr_idx;
    logic                 sel_ok;
    logic                 in_range;
    logic                 wr_valid;
    logic                 wr_bad;
    logic                 wr_store;
    logic                 bypass_en;

    onehot_enc_64 u_enc (
        .vec       (wr_sel),
        .idx       (wr_idx),
        .onehot_ok (sel_ok)
    );

    assign in_range  = int'(wr_idx) < NREGS;
    assign wr_valid  = wr_en && sel_ok && in_range;
    assign wr_bad    = wr_en && !(sel_ok && in_range);
    assign wr_store  = wr_valid && (int'(wr_idx) != ZERO_REG);
    // Gated by reset so read data stays zero while the array is held clear.
    assign bypass_en = rst_n && wr_store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_store && wr_idx == REG_IDX_W'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_a_data = '0;
        rd_b_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i != ZERO_REG) begin
                if (rd_a_idx == REG_IDX_W'(i)) begin
                    rd_a_data = regs[i];
                end
                if (rd_b_idx == REG_IDX_W'(i)) begin
                    rd_b_data = regs[i];
                end
            end
        end
        if (bypass_en && rd_a_idx == wr_idx) begin
            rd_a_data = wr_data;
        end
        if (bypass_en && rd_b_idx == wr_idx) begin
            rd_b_data = wr_data;
        end
    end

    // A malformed write in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err      <= 1'b0;
            last_wr_idx <= '0;
            last_wr_vld <= 1'b0;
        end else begin
            if (wr_bad) begin
                wr_err <= 1'b1;
            end else if (err_clr) begin
                wr_err <= 1'b0;
            end
            if (wr_valid) begin
                last_wr_idx <= wr_idx;
                last_wr_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed bench for regfile_onehot_wr: expectations are queued as stimulus
// is applied and drained against the DUT outputs at each observation point.
module tb_regfile_onehot_wr;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [63:0] wr_sel;
    logic [63:0] wr_data;
    logic [5:0]  rd_a_idx;
    logic [5:0]  rd_b_idx;
    logic [63:0] rd_a_data;
    logic [63:0] rd_b_data;
    logic        wr_err;
    logic        err_clr;
    logic [5:0]  last_wr_idx;
    logic        last_wr_vld;

    typedef enum int {SEL_RDA, SEL_RDB, SEL_ERR, SEL_IDX, SEL_VLD} obs_sel_e;

    typedef struct {
        string       tag;
        obs_sel_e    sel;
        logic [63:0] exp;
    } exp_t;

    exp_t scoreboard[$];
    int   checks;
    int   failures;

    regfile_onehot_wr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .rd_a_idx    (rd_a_idx),
        .rd_b_idx    (rd_b_idx),
        .rd_a_data   (rd_a_data),
        .rd_b_data   (rd_b_data),
        .wr_err      (wr_err),
        .err_clr     (err_clr),
        .last_wr_idx (last_wr_idx),
        .last_wr_vld (last_wr_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic en, input logic [63:0] sel,
                                  input logic [63:0] data, input logic clr,
                                  input logic [5:0] ra, input logic [5:0] rb);
        wr_en    = en;
        wr_sel   = sel;
        wr_data  = data;
        err_clr  = clr;
        rd_a_idx = ra;
        rd_b_idx = rb;
    endtask

    task automatic expect_val(input string tag, input obs_sel_e sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        scoreboard.push_back(e);
    endtask

    task automatic check_output();
        exp_t        e;
        logic [63:0] obs;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            case (e.sel)
                SEL_RDA: obs = rd_a_data;
                SEL_RDB: obs = rd_b_data;
                SEL_ERR: obs = {63'd0, wr_err};
                SEL_IDX: obs = {58'd0, last_wr_idx};
                default: obs = {63'd0, last_wr_vld};
            endcase
            checks++;
            assert (obs === e.exp)
            else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Step past the next rising edge and settle before observing.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'd0, 6'd0);
        tick();
        tick();

        // A valid write presented during reset must neither bypass nor commit.
        apply_stimulus(1'b1, 64'h4, 64'hAAAA_5555_AAAA_5555, 1'b0, 6'd2, 6'd2);
        #1;
        expect_val("rst_bypass_a", SEL_RDA, 64'd0);
        expect_val("rst_bypass_b", SEL_RDB, 64'd0);
        check_output();
        tick();
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'd0, 6'd0);
        #2;
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 32; i++) begin
            apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'(i), 6'(31 - i));
            #1;
            expect_val($sformatf("rst_rd_a_%0d", i), SEL_RDA, 64'd0);
            expect_val($sformatf("rst_rd_b_%0d", 31 - i), SEL_RDB, 64'd0);
            check_output();
        end
        expect_val("rst_err", SEL_ERR, 64'd0);
        expect_val("rst_vld", SEL_VLD, 64'd0);
        expect_val("rst_idx", SEL_IDX, 64'd0);
        check_output();

        // Basic write to reg 2, visible through the bypass then the array.
        apply_stimulus(1'b1, 64'h4, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 6'd2, 6'd3);
        #1;
        expect_val("wr2_bypass_a", SEL_RDA, 64'hDEAD_BEEF_CAFE_F00D);
        expect_val("wr2_other_b", SEL_RDB, 64'd0);
        check_output();
        tick();
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'd2, 6'd3);
        #1;
        expect_val("wr2_rd_a", SEL_RDA, 64'hDEAD_BEEF_CAFE_F00D);
        expect_val("wr2_rd_b3", SEL_RDB, 64'd0);
        expect_val("wr2_idx", SEL_IDX, 64'd2);
        expect_val("wr2_vld", SEL_VLD, 64'd1);
        check_output();

        // Both ports bypass the same in-flight write.
        apply_stimulus(1'b1, 64'h20, 64'h1234, 1'b0, 6'd5, 6'd5);
        #1;
        expect_val("byp5_a", SEL_RDA, 64'h1234);
        expect_val("byp5_b", SEL_RDB, 64'h1234);
        check_output();
        tick();
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'd5, 6'd5);
        #1;
        expect_val("arr5_a", SEL_RDA, 64'h1234);
        expect_val("arr5_b", SEL_RDB, 64'h1234);
        expect_val("arr5_idx", SEL_IDX, 64'd5);
        check_output();

        // Independent bypass: port A hits the write, port B reads stored reg 2.
        apply_stimulus(1'b1, 64'h40, 64'h6666, 1'b0, 6'd6, 6'd2);
        #1;
        expect_val("byp6_a", SEL_RDA, 64'h6666);
        expect_val("byp6_b_old", SEL_RDB, 64'hDEAD_BEEF_CAFE_F00D);
        check_output();
        tick();

        // Zero register swallows writes but still updates commit tracking.
        apply_stimulus(1'b1, 64'h8000_0000, 64'hFFFF, 1'b0, 6'd31, 6'd31);
        #1;
        expect_val("zr_no_bypass", SEL_RDA, 64'd0);
        check_output();
        tick();
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'd31, 6'd40);
        #1;
        expect_val("zr_rd", SEL_RDA, 64'd0);
        expect_val("oob_rd40", SEL_RDB, 64'd0);
        expect_val("zr_err", SEL_ERR, 64'd0);
        expect_val("zr_idx", SEL_IDX, 64'd31);
        check_output();

        apply_stimulus(1'b1, 64'h2, 64'h11, 1'b0, 6'd1, 6'd2);
        tick();

        // Two-hot select: no bypass, no store, error flagged, tracking frozen.
        apply_stimulus(1'b1, 64'h6, 64'hBAD0, 1'b0, 6'd1, 6'd2);
        #1;
        expect_val("bad6_nobyp_a", SEL_RDA, 64'h11);
        expect_val("bad6_nobyp_b", SEL_RDB, 64'hDEAD_BEEF_CAFE_F00D);
        check_output();
        tick();
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'd1, 6'd2);
        #1;
        expect_val("bad6_r1", SEL_RDA, 64'h11);
        expect_val("bad6_r2", SEL_RDB, 64'hDEAD_BEEF_CAFE_F00D);
        expect_val("bad6_err", SEL_ERR, 64'd1);
        expect_val("bad6_idx", SEL_IDX, 64'd1);
        check_output();

        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b1, 6'd1, 6'd2);
        tick();
        expect_val("clr1_err", SEL_ERR, 64'd0);
        check_output();

        // With wr_en low the select is ignored, even when malformed.
        apply_stimulus(1'b0, 64'h6, 64'hBAD1, 1'b0, 6'd1, 6'd2);
        tick();
        expect_val("dis_err", SEL_ERR, 64'd0);
        expect_val("dis_r1", SEL_RDA, 64'h11);
        check_output();

        // In-range one-hot but past NREGS.
        apply_stimulus(1'b1, 64'h1_0000_0000, 64'hBAD2, 1'b0, 6'd32, 6'd0);
        tick();
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'd32, 6'd0);
        #1;
        expect_val("oob32_err", SEL_ERR, 64'd1);
        expect_val("oob32_rd", SEL_RDA, 64'd0);
        expect_val("oob32_idx", SEL_IDX, 64'd1);
        check_output();

        // Set and clear in the same cycle: set wins.
        apply_stimulus(1'b1, 64'd0, 64'hBAD3, 1'b1, 6'd0, 6'd0);
        tick();
        expect_val("setclr_err", SEL_ERR, 64'd1);
        check_output();
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b1, 6'd0, 6'd0);
        tick();
        expect_val("clr2_err", SEL_ERR, 64'd0);
        check_output();

        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b1, 64'd1 << i, 64'h100 + 64'(i), 1'b0, 6'd0, 6'd0);
            tick();
        end
        apply_stimulus(1'b1, 64'h3, 64'd0, 1'b0, 6'd3, 6'd4);
        tick();
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'd3, 6'd4);
        #1;
        expect_val("pre_rst_r3", SEL_RDA, 64'h103);
        expect_val("pre_rst_r4", SEL_RDB, 64'h104);
        expect_val("pre_rst_err", SEL_ERR, 64'd1);
        expect_val("pre_rst_idx", SEL_IDX, 64'd4);
        check_output();

        // Asynchronous reset between edges clears everything immediately.
        #1;
        rst_n = 1'b0;
        #1;
        expect_val("arst_r3", SEL_RDA, 64'd0);
        expect_val("arst_r4", SEL_RDB, 64'd0);
        expect_val("arst_err", SEL_ERR, 64'd0);
        expect_val("arst_vld", SEL_VLD, 64'd0);
        expect_val("arst_idx", SEL_IDX, 64'd0);
        check_output();
        apply_stimulus(1'b0, 64'd0, 64'd0, 1'b0, 6'd1, 6'd2);
        #1;
        expect_val("arst_r1", SEL_RDA, 64'd0);
        expect_val("arst_r2", SEL_RDB, 64'd0);
        check_output();
        tick();
        rst_n = 1'b1;
        tick();
        expect_val("post_rst_r1", SEL_RDA, 64'd0);
        expect_val("post_rst_vld", SEL_VLD, 64'd0);
        check_output();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
